// File: rtl/core_pkg.sv
// Shared types for the integer core pipeline: destination-register tags
// and the per-cycle sequencing decision used by pipe_ctrl.
package core_pkg;

    localparam int NUM_TAG_STAGES = 3;
    localparam int REG_ADDR_W     = 5;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
    } rd_tag_t;

    typedef enum logic [1:0] {
        CTRL_ADV,
        CTRL_STALL,
        CTRL_FLUSH,
        CTRL_FREEZE
    } ctrl_e;

    // x0 is hard-wired zero, so a tag naming it never creates a dependency.
    function automatic logic tag_matches(rd_tag_t tag, logic [REG_ADDR_W-1:0] addr);
        return tag.valid && (tag.rd != '0) && (tag.rd == addr);
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Three-entry shift register of destination tags for the E, M and W stages.
// Index 0 is E, 1 is M, 2 is W; the W entry retires on each shifting edge.
module rd_tag_pipe
    import core_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               shift,
    input  logic                               insert_bubble,
    input  logic                               hold_EM,
    input  rd_tag_t                            new_tag,
    output rd_tag_t [NUM_TAG_STAGES-1:0]       tags
);

    // NOTE: state uses non-blocking assignments so every stage samples the
    // pre-edge value of its neighbour; blocking here would collapse the shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            tags <= '0;
        end else if (hold_EM) begin
            // Memory stall: E and M hold, W still writes back and drains.
            tags[2] <= '0;
        end else if (shift) begin
            tags[2] <= tags[1];
            tags[1] <= tags[0];
            tags[0] <= insert_bubble ? '0 : new_tag;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: RAW-hazard stall, redirect flush and
// data-memory freeze for the five-stage core, plus stall/flush counters.
module pipe_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    valid_D,
    input  logic [REG_ADDR_W-1:0]                   rs1_addr_D,
    input  logic [REG_ADDR_W-1:0]                   rs2_addr_D,
    input  logic                                    rs1_used_D,
    input  logic                                    rs2_used_D,
    input  logic [REG_ADDR_W-1:0]                   rd_addr_D,
    input  logic                                    rd_we_D,
    input  logic                                    redirect_E,
    input  logic                                    mem_busy_M,
    output logic                                    stall_F,
    output logic                                    stall_D,
    output logic                                    flush_D,
    output logic                                    bubble_E,
    output logic                                    hold_EM,
    output logic [NUM_TAG_STAGES-1:0][REG_ADDR_W-1:0] rd_addr,
    output logic [CNT_W-1:0]                        stall_cnt,
    output logic [CNT_W-1:0]                        flush_cnt
);

    rd_tag_t [NUM_TAG_STAGES-1:0] tags;
    rd_tag_t                      new_tag;
    ctrl_e                        ctrl;
    logic                         haz;

    assign new_tag = '{valid: valid_D & rd_we_D, rd: rd_addr_D};

    rd_tag_pipe u_tag_pipe (
        .clk           (clk),
        .rst           (rst),
        .shift         (ctrl != CTRL_FREEZE),
        .insert_bubble ((ctrl == CTRL_STALL) || (ctrl == CTRL_FLUSH)),
        .hold_EM       (ctrl == CTRL_FREEZE),
        .new_tag       (new_tag),
        .tags          (tags)
    );

    // No forwarding: any live producer in E, M or W blocks the reader.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        haz = 1'b0;
        for (int i = 0; i < NUM_TAG_STAGES; i++) begin
            if ((rs1_used_D && tag_matches(tags[i], rs1_addr_D)) ||
                (rs2_used_D && tag_matches(tags[i], rs2_addr_D)))
                haz = 1'b1;
        end
        haz = haz & valid_D;
    end

    always_comb begin
        ctrl = CTRL_ADV;
        if (mem_busy_M)      ctrl = CTRL_FREEZE;
        else if (redirect_E) ctrl = CTRL_FLUSH;
        else if (haz)        ctrl = CTRL_STALL;
    end

    always_comb begin
        stall_F  = 1'b0;
        stall_D  = 1'b0;
        flush_D  = 1'b0;
        bubble_E = 1'b0;
        hold_EM  = 1'b0;
        unique case (ctrl)
            CTRL_FREEZE: begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                hold_EM = 1'b1;
            end
            CTRL_FLUSH: begin
                flush_D  = 1'b1;
                bubble_E = 1'b1;
            end
            CTRL_STALL: begin
                stall_F  = 1'b1;
                stall_D  = 1'b1;
                bubble_E = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_addr = '0;
        for (int i = 0; i < NUM_TAG_STAGES; i++)
            rd_addr[i] = tags[i].valid ? tags[i].rd : '0;
    end

    // Counters wrap freely; reset wins over any decision in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (ctrl == CTRL_STALL) stall_cnt <= stall_cnt + CNT_W'(1);
            if (ctrl == CTRL_FLUSH) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a reference model of in-flight writers
// predicts each cycle's outputs, and a negedge monitor compares them.
module tb_pipe_ctrl;
    import core_pkg::*;

    localparam int CNT_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                             rst, valid_D, rs1_used_D, rs2_used_D, rd_we_D;
    logic [4:0]                       rs1_addr_D, rs2_addr_D, rd_addr_D;
    logic                             redirect_E, mem_busy_M;
    logic                             stall_F, stall_D, flush_D, bubble_E, hold_EM;
    logic [NUM_TAG_STAGES-1:0][4:0]   rd_addr;
    logic [CNT_W-1:0]                 stall_cnt, flush_cnt;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .valid_D(valid_D),
        .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
        .rd_addr_D(rd_addr_D), .rd_we_D(rd_we_D),
        .redirect_E(redirect_E), .mem_busy_M(mem_busy_M),
        .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D),
        .bubble_E(bubble_E), .hold_EM(hold_EM), .rd_addr(rd_addr),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic                           stall_F, stall_D, flush_D, bubble_E, hold_EM;
        logic [NUM_TAG_STAGES-1:0][4:0] rd_addr;
        logic [CNT_W-1:0]               stall_cnt, flush_cnt;
    } obs_t;

    // Reference model: each in-flight writer of a non-zero register with the
    // number of edges left until it retires (3 = in E, 2 = in M, 1 = in W).
    typedef struct {
        int rd;
        int left;
    } writer_t;

    writer_t writers[$];
    int      m_stalls = 0;
    int      m_flushes = 0;
    obs_t    exp_q[$];
    int      checks = 0;
    int      failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic reg_pending(input logic [4:0] r);
        foreach (writers[i])
            if (writers[i].rd == int'(r)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic model_haz();
        return valid_D && ((rs1_used_D && reg_pending(rs1_addr_D)) ||
                           (rs2_used_D && reg_pending(rs2_addr_D)));
    endfunction

    function automatic obs_t model_outputs();
        obs_t o;
        o = '0;
        if (mem_busy_M) begin
            o.stall_F = 1'b1; o.stall_D = 1'b1; o.hold_EM = 1'b1;
        end else if (redirect_E) begin
            o.flush_D = 1'b1; o.bubble_E = 1'b1;
        end else if (model_haz()) begin
            o.stall_F = 1'b1; o.stall_D = 1'b1; o.bubble_E = 1'b1;
        end
        foreach (writers[i])
            o.rd_addr[3 - writers[i].left] = 5'(writers[i].rd);
        o.stall_cnt = CNT_W'(m_stalls);
        o.flush_cnt = CNT_W'(m_flushes);
        return o;
    endfunction

    // Applies the spec's edge rules to the writer list using the inputs
    // that were present during the cycle just finished.
    task automatic model_edge(input logic busy, input logic redir, input logic haz);
        writer_t kept[$];
        if (rst) begin
            writers.delete();
            m_stalls  = 0;
            m_flushes = 0;
            return;
        end
        foreach (writers[i]) begin
            if (busy) begin
                if (writers[i].left != 1) kept.push_back(writers[i]);
            end else if (writers[i].left > 1) begin
                kept.push_back('{writers[i].rd, writers[i].left - 1});
            end
        end
        writers = kept;
        if (!busy && redir)      m_flushes++;
        else if (!busy && haz)   m_stalls++;
        else if (!busy && valid_D && rd_we_D && rd_addr_D != 5'd0)
            writers.push_back('{int'(rd_addr_D), 3});
    endtask

    task automatic step(input logic r, input logic v,
                        input logic [4:0] a1, input logic u1,
                        input logic [4:0] a2, input logic u2,
                        input logic [4:0] d, input logic w,
                        input logic re, input logic mb);
        logic haz;
        rst = r; valid_D = v; rs1_addr_D = a1; rs1_used_D = u1;
        rs2_addr_D = a2; rs2_used_D = u2; rd_addr_D = d; rd_we_D = w;
        redirect_E = re; mem_busy_M = mb;
        haz = model_haz();
        exp_q.push_back(model_outputs());
        @(posedge clk);
        #1;
        model_edge(mb, re, haz);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 1, 5'd5, 1, 5'd6, 1, 5'd5, 1, 0, 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a.stall_F = stall_F; a.stall_D = stall_D; a.flush_D = flush_D;
            a.bubble_E = bubble_E; a.hold_EM = hold_EM; a.rd_addr = rd_addr;
            a.stall_cnt = stall_cnt; a.flush_cnt = flush_cnt;
            check("outputs", 64'(a), 64'(e));
        end
    end

    initial begin
        rst = 1'b1; valid_D = 1'b1; rs1_addr_D = 5'd5; rs1_used_D = 1'b1;
        rs2_addr_D = 5'd0; rs2_used_D = 1'b0; rd_addr_D = 5'd5; rd_we_D = 1'b1;
        redirect_E = 1'b0; mem_busy_M = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        check("reset_cnt", 64'({stall_cnt, flush_cnt}), 64'd0);
        check("reset_tags", 64'(rd_addr), 64'd0);

        // Back-to-back RAW: reader of x5 stalls 3 cycles, then enters E.
        step(0, 1, 5'd1, 1, 5'd2, 0, 5'd5, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 5'd5, 1, 5'd0, 0, 5'd9, 1, 0, 0);
        check("raw_stall_cnt", 64'(stall_cnt), 64'd3);
        check("raw_reader_in_E", 64'(rd_addr[0]), 64'd9);
        idle(3);

        // Two independent instructions between producer and reader: 1 stall.
        do_reset();
        step(0, 1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0);
        step(0, 1, 5'd1, 1, 5'd2, 1, 5'd10, 1, 0, 0);
        step(0, 1, 5'd1, 1, 5'd2, 1, 5'd11, 1, 0, 0);
        step(0, 1, 5'd3, 1, 5'd7, 1, 5'd12, 1, 0, 0);
        step(0, 1, 5'd3, 1, 5'd7, 1, 5'd12, 1, 0, 0);
        check("dist2_stall_cnt", 64'(stall_cnt), 64'd1);
        step(0, 1, 5'd1, 0, 5'd1, 0, 5'd0, 1, 0, 0);
        step(0, 1, 5'd0, 1, 5'd0, 1, 5'd13, 1, 0, 0);
        check("x0_no_stall", 64'(stall_cnt), 64'd1);
        idle(3);

        // Redirect beats a live hazard on x3.
        do_reset();
        step(0, 1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0);
        step(0, 1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 1, 0);
        check("redir_flush_cnt", 64'(flush_cnt), 64'd1);
        check("redir_stall_cnt", 64'(stall_cnt), 64'd0);
        idle(3);

        // Freeze for 4 cycles with a redirect pending from the second on.
        do_reset();
        for (int i = 1; i <= 3; i++) step(0, 1, 5'd0, 0, 5'd0, 0, 5'(i), 1, 0, 0);
        step(0, 1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 0, 1);
        check("freeze_tags", 64'(rd_addr), 64'({5'd0, 5'd2, 5'd3}));
        for (int i = 0; i < 3; i++) step(0, 1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 1, 1);
        check("freeze_no_flush", 64'(flush_cnt), 64'd0);
        step(0, 1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 1, 0);
        check("freeze_then_flush", 64'(flush_cnt), 64'd1);
        idle(3);

        // Reset during the second stall cycle of a RAW.
        do_reset();
        step(0, 1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0, 0);
        step(0, 1, 5'd4, 1, 5'd0, 0, 5'd6, 1, 0, 0);
        step(1, 1, 5'd4, 1, 5'd0, 0, 5'd6, 1, 0, 0);
        check("midreset_cnt", 64'(stall_cnt), 64'd0);
        check("midreset_tags", 64'(rd_addr), 64'd0);
        step(0, 1, 5'd4, 1, 5'd0, 0, 5'd6, 1, 0, 0);

        // Randomized traffic; small register range keeps hazards frequent.
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(199) == 0, $urandom_range(3) != 0,
                 5'($urandom_range(7)), $urandom_range(1) == 1,
                 5'($urandom_range(7)), $urandom_range(1) == 1,
                 5'($urandom_range(7)), $urandom_range(3) != 0,
                 $urandom_range(9) == 0, $urandom_range(7) == 0);
        end

        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
